// File: rtl/vid_pkg.sv
// vid_pkg: shared video timing presets, polarity constants and pixel type
package vid_pkg;
  typedef struct packed {
    int   h_active;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_active;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic h_pol;
    logic v_pol;
  } vid_timing_t;
  localparam logic POL_LOW = 1'b0;
  localparam logic POL_HIGH = 1'b1;
  localparam vid_timing_t VGA_640X480 = '{640, 16, 96, 48, 480, 10, 2, 33, POL_LOW, POL_LOW};
  localparam vid_timing_t HD_1280X720 = '{1280, 110, 40, 220, 720, 5, 5, 20, POL_HIGH, POL_HIGH};
  typedef logic [23:0] rgb_t;
endpackage

// File: rtl/vid_delay.sv
// vid_delay: N-stage register delay line with a configurable reset value
module vid_delay #(
  parameter int W = 1,
  parameter int N = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r_sr [N];
  // shift d through N registers, clearing every stage to RST on reset
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < N; i++) r_sr[i] <= RST;
    else begin
      r_sr[0] <= d;
      for (int i = 1; i < N; i++) r_sr[i] <= r_sr[i-1];
    end
  assign q = r_sr[N-1];
endmodule

// File: rtl/vid_scan_ctrl.sv
// vid_scan_ctrl: video timing, replicated framebuffer addressing and latency-matched sync
module vid_scan_ctrl
  import vid_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_640X480.h_active,
  parameter int   H_FP = VGA_640X480.h_fp,
  parameter int   H_SYNC = VGA_640X480.h_sync,
  parameter int   H_BP = VGA_640X480.h_bp,
  parameter int   V_ACTIVE = VGA_640X480.v_active,
  parameter int   V_FP = VGA_640X480.v_fp,
  parameter int   V_SYNC = VGA_640X480.v_sync,
  parameter int   V_BP = VGA_640X480.v_bp,
  parameter logic H_POL = POL_LOW,
  parameter logic V_POL = POL_LOW,
  parameter int   SCALE_LOG2 = 0,
  parameter int   RAM_LAT = 1,
  parameter int   PIX_W = 24,
  parameter int   ADDR_W = $clog2((H_ACTIVE * V_ACTIVE) >> (2 * SCALE_LOG2))
) (
  input  logic              clk_pix,
  input  logic              rst,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  pix_o,
  output logic              de_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [VW-1:0] V_MASK = VW'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] SRC_W = ADDR_W'(H_ACTIVE >> SCALE_LOG2);
  logic [HW-1:0]     r_h;
  logic [VW-1:0]     r_v;
  logic [ADDR_W-1:0] r_line_base;
  logic              w_h_end, w_v_end, w_de, w_hs, w_vs, w_fs, w_line_end;
  logic [3:0]        w_dly;
  // raw timing decode from the current counter position
  always_comb begin
    w_h_end = r_h == HW'(H_TOTAL - 1);
    w_v_end = r_v == VW'(V_TOTAL - 1);
    w_de = (r_h < HW'(H_ACTIVE)) && (r_v < VW'(V_ACTIVE));
    w_hs = (r_h >= HW'(H_ACTIVE + H_FP)) && (r_h <= HW'(H_ACTIVE + H_FP + H_SYNC - 1)) ? H_POL : ~H_POL;
    w_vs = (r_v >= VW'(V_ACTIVE + V_FP)) && (r_v <= VW'(V_ACTIVE + V_FP + V_SYNC - 1)) ? V_POL : ~V_POL;
    w_fs = (r_h == '0) && (r_v == '0);
    w_line_end = (r_h == HW'(H_ACTIVE - 1)) && (r_v < VW'(V_ACTIVE)) && ((r_v & V_MASK) == V_MASK);
  end
  // h/v counters and source line base; the base only advances after the last replicated copy of a line
  always_ff @(posedge clk_pix)
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
      r_line_base <= '0;
    end else begin
      r_h <= w_h_end ? '0 : r_h + 1'b1;
      if (w_h_end) r_v <= w_v_end ? '0 : r_v + 1'b1;
      if (w_h_end && w_v_end) r_line_base <= '0;
      else if (w_line_end) r_line_base <= r_line_base + SRC_W;
    end
  // read request stage; the address holds its last value through blanking
  always_ff @(posedge clk_pix)
    if (rst) begin
      rd_en <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_en <= w_de;
      if (w_de) rd_addr <= r_line_base + ADDR_W'(r_h >> SCALE_LOG2);
    end
  vid_delay #(.W(4), .N(RAM_LAT + 1), .RST({2'b00, ~V_POL, ~H_POL})) u_dly (
    .clk(clk_pix),
    .rst(rst),
    .d({w_fs, w_de, w_vs, w_hs}),
    .q(w_dly)
  );
  // output stage aligning pixel data with the delayed sync/enable
  always_ff @(posedge clk_pix)
    if (rst) begin
      pix_o <= '0;
      de_o <= 1'b0;
      hsync_o <= ~H_POL;
      vsync_o <= ~V_POL;
      frame_start <= 1'b0;
    end else begin
      pix_o <= w_dly[2] ? rd_data : '0;
      {frame_start, de_o, vsync_o, hsync_o} <= w_dly;
    end
endmodule
